tmr_vote_seq: RTL and testbench

Bit-serial triple-modular-redundancy voting sequencer that time-shares one external AO5 cell (3-input AND-NOR, i.e. inverted majority) to vote three redundant WIDTH-bit words. Sits between redundant register copies and consumers. Accepts one word triple per valid/ready handshake and walks it LSB-first through the shared cell. Returns the voted word plus per-channel disagreement flags.

---
 rtl/tmr_vote_seq_if.sv | 39 +++
 rtl/tmr_vote_seq.sv | 182 ++++++++++++++++++
 tb/tb_tmr_vote_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_vote_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmr_vote_seq_if                                           |
// | Brief    : Request, result and shared AO5 cell signals of the TMR    |
// |            voting sequencer. slave = sequencer, master = environment.|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface tmr_vote_seq_if #(
  parameter int WIDTH = 8
);
  // request side
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [WIDTH-1:0] A_DATA;
  logic [WIDTH-1:0] B_DATA;
  logic [WIDTH-1:0] C_DATA;
  // shared AO5 cell (inverted majority)
  logic             VA;
  logic             VB;
  logic             VC;
  logic             VZ;
  // result side
  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_DATA;
  logic [2:0]       ERR;
  logic             CELL_FAULT;

  modport slave (
    input  REQ_VALID, A_DATA, B_DATA, C_DATA, VZ, RES_READY,
    output REQ_READY, VA, VB, VC, RES_VALID, RES_DATA, ERR, CELL_FAULT
  );

  modport master (
    output REQ_VALID, A_DATA, B_DATA, C_DATA, VZ, RES_READY,
    input  REQ_READY, VA, VB, VC, RES_VALID, RES_DATA, ERR, CELL_FAULT
  );
endinterface
`default_nettype wire

// File: rtl/tmr_vote_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmr_vote_seq                                              |
// | Brief    : Bit-serial TMR voter. Walks one accepted word triple      |
// |            LSB-first through a shared external AO5 cell and returns  |
// |            the voted word plus per-channel disagreement flags.       |
// |            Optional macro TMR_VOTE_CHECK_EN adds a local majority    |
// |            check of the cell, reported on sticky CELL_FAULT.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tmr_vote_seq #(
  parameter int WIDTH = 8
) (
  input  wire            CP,
  input  wire            RN,
  tmr_vote_seq_if.slave  bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VOTE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic [WIDTH-1:0] c_sh_q,      c_sh_d;
  logic             va_q,        va_d;
  logic             vb_q,        vb_d;
  logic             vc_q,        vc_d;
  logic             req_ready_q, req_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic [2:0]       err_q,       err_d;

  // The cell is an inverted majority, so the vote of the presented bits is ~VZ.
  logic voted_bit;
  logic accept;

  assign voted_bit = ~bus.VZ;
  assign accept    = (state_q == ST_IDLE) && bus.REQ_VALID && req_ready_q;

  // Next-state and datapath: load on accept, shift one bit per VOTE cycle, hold in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    c_sh_d      = c_sh_q;
    va_d        = 1'b0;
    vb_d        = 1'b0;
    vc_d        = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Bit 0 goes straight to the cell drivers; the rest wait in the shifters.
          va_d    = bus.A_DATA[0];
          vb_d    = bus.B_DATA[0];
          vc_d    = bus.C_DATA[0];
          a_sh_d  = bus.A_DATA >> 1;
          b_sh_d  = bus.B_DATA >> 1;
          c_sh_d  = bus.C_DATA >> 1;
          err_d   = 3'b000;
          cnt_d   = '0;
          state_d = ST_VOTE;
        end
      end

      ST_VOTE: begin
        // Shift the vote in at the MSB; after WIDTH cycles bit 0 lands at the LSB.
        res_data_d = {voted_bit, res_data_q[WIDTH-1:1]};
        err_d      = err_q | ({vc_q, vb_q, va_q} ^ {3{voted_bit}});
        if (cnt_q == LAST_BIT) begin
          // Counter parks on the last bit rather than wrapping; drivers fall to 0.
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          va_d   = a_sh_q[0];
          vb_d   = b_sh_q[0];
          vc_d   = c_sh_q[0];
          a_sh_d = a_sh_q >> 1;
          b_sh_d = b_sh_q >> 1;
          c_sh_d = c_sh_q >> 1;
        end
      end

      ST_DONE: begin
        if (bus.RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // Ready is registered, so it reflects whether the next cycle is IDLE.
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CP) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      c_sh_q      <= '0;
      va_q        <= 1'b0;
      vb_q        <= 1'b0;
      vc_q        <= 1'b0;
      req_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      c_sh_q      <= c_sh_d;
      va_q        <= va_d;
      vb_q        <= vb_d;
      vc_q        <= vc_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.REQ_READY = req_ready_q;
  assign bus.RES_VALID = res_valid_q;
  assign bus.RES_DATA  = res_data_q;
  assign bus.ERR       = err_q;
  assign bus.VA        = va_q;
  assign bus.VB        = vb_q;
  assign bus.VC        = vc_q;

`ifdef TMR_VOTE_CHECK_EN
  logic cell_fault_q, cell_fault_d;
  logic local_maj;

  assign local_maj = (va_q & vb_q) | (va_q & vc_q) | (vb_q & vc_q);

  // Sticky flag: the external cell disagreed with the local majority of the presented bits.
  always_comb begin
    cell_fault_d = cell_fault_q;
    if ((state_q == ST_VOTE) && (local_maj != voted_bit)) begin
      cell_fault_d = 1'b1;
    end
  end

  // Fault flag register; only reset clears it.
  always_ff @(posedge CP) begin
    if (!RN) begin
      cell_fault_q <= 1'b0;
    end else begin
      cell_fault_q <= cell_fault_d;
    end
  end

  assign bus.CELL_FAULT = cell_fault_q;
`else
  assign bus.CELL_FAULT = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmr_vote_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tmr_vote_seq                                           |
// | Brief    : Self-checking bench for tmr_vote_seq with a behavioural   |
// |            AO5 cell and a bit-count majority reference model.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_tmr_vote_seq;

  localparam int W = 8;

`ifdef TMR_VOTE_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rn  = 1'b0;
  logic force_z = 1'b0;
  int   cyc = 0;
  int   n_asserts = 0;
  int   n_fail = 0;
  logic fault_exp = 1'b0;

  tmr_vote_seq_if #(.WIDTH(W)) bus ();

  tmr_vote_seq #(.WIDTH(W)) dut (
    .CP  (clk),
    .RN  (rn),
    .bus (bus.slave)
  );

  // Behavioural AO5 cell: Z = ~majority(A,B,C), optionally stuck at 0.
  assign bus.VZ = force_z ? 1'b0
                          : ~((bus.VA & bus.VB) | (bus.VA & bus.VC) | (bus.VB & bus.VC));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-bit population count, majority when at least two ones.
  function automatic logic [W-1:0] ref_vote(input logic [W-1:0] a, b, c);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      v[i] = (ones >= 2);
    end
    return v;
  endfunction

  function automatic logic [2:0] ref_err(input logic [W-1:0] a, b, c, v);
    return {(c != v), (b != v), (a != v)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: wait for ready, accept, check each presented bit, check result.
  task automatic run_txn(input logic [W-1:0] a, b, c, input int hold,
                         input bit expect_now, input bit leave_valid,
                         input logic [W-1:0] na, nb, nc);
    logic [W-1:0] model_v, ev;
    logic [2:0]   ee;
    int           t, acc;
    model_v = ref_vote(a, b, c);
    ev      = force_z ? {W{1'b1}} : model_v;
    ee      = ref_err(a, b, c, ev);
    bus.A_DATA = a;
    bus.B_DATA = b;
    bus.C_DATA = c;
    bus.REQ_VALID = 1'b1;
    t = 0;
    while (bus.REQ_READY !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk("accept_timeout", 32'(t < 40), 32'd1);
    if (expect_now) chk("accept_wait", t, 0);
    step();
    acc = cyc;
    bus.REQ_VALID = 1'b0;
    chk("req_ready_drop", 32'(bus.REQ_READY), 32'd0);
    for (int n = 0; n < W; n++) begin
      chk("present_bits", {bus.VA, bus.VB, bus.VC}, {a[n], b[n], c[n]});
      chk("res_valid_early", 32'(bus.RES_VALID), 32'd0);
      if (n >= 1 && CHECK_ON && force_z && !model_v[n-1]) fault_exp = 1'b1;
      if (n >= 1) chk("cell_fault_vote", 32'(bus.CELL_FAULT), 32'(fault_exp));
      // Ready outside DONE must be ignored.
      bus.RES_READY = 1'($urandom_range(0, 1));
      step();
    end
    bus.RES_READY = 1'b0;
    if (CHECK_ON && force_z && !model_v[W-1]) fault_exp = 1'b1;
    chk("latency", cyc - acc, W);
    chk("res_valid", 32'(bus.RES_VALID), 32'd1);
    chk("res_data", 32'(bus.RES_DATA), 32'(ev));
    chk("err", 32'(bus.ERR), 32'(ee));
    chk("drivers_idle", {bus.VA, bus.VB, bus.VC}, 3'b000);
    chk("req_ready_done", 32'(bus.REQ_READY), 32'd0);
    chk("cell_fault_done", 32'(bus.CELL_FAULT), 32'(fault_exp));
    if (leave_valid) begin
      bus.A_DATA = na;
      bus.B_DATA = nb;
      bus.C_DATA = nc;
      bus.REQ_VALID = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(bus.RES_VALID), 32'd1);
      chk("hold_data", 32'(bus.RES_DATA), 32'(ev));
      chk("hold_err", 32'(bus.ERR), 32'(ee));
      chk("hold_req_ready", 32'(bus.REQ_READY), 32'd0);
    end
    bus.RES_READY = 1'b1;
    step();
    bus.RES_READY = 1'b0;
    chk("res_valid_drop", 32'(bus.RES_VALID), 32'd0);
    chk("req_ready_back", 32'(bus.REQ_READY), 32'd1);
  endtask

  // Stimulus: directed steps followed by a randomized run.
  initial begin
    logic [W-1:0] a, b, c, d1a, d1b, d1c, d2a, d2b, d2c, v;
    int c1, c2, t;
    bit got1, prev_ready;

    bus.REQ_VALID = 1'b0;
    bus.RES_READY = 1'b0;
    bus.A_DATA = '0;
    bus.B_DATA = '0;
    bus.C_DATA = '0;

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
    chk("rst_res_data", 32'(bus.RES_DATA), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_drivers", {bus.VA, bus.VB, bus.VC}, 3'b000);
    chk("rst_cell_fault", 32'(bus.CELL_FAULT), 32'd0);
    rn = 1'b1;
    step();
    chk("ready_after_rst", 32'(bus.REQ_READY), 32'd1);

    // All channels agree
    run_txn(8'hA5, 8'hA5, 8'hA5, 0, 1'b1, 1'b0, '0, '0, '0);
    // Two channels outvoted on different bits
    run_txn(8'hFF, 8'h00, 8'h0F, 1, 1'b0, 1'b0, '0, '0, '0);

    // Backpressure with REQ_VALID held, then accept two edges after release
    run_txn(8'h3C, 8'h3D, 8'h7C, 5, 1'b0, 1'b1, 8'h12, 8'h12, 8'h92);
    run_txn(8'h12, 8'h12, 8'h92, 0, 1'b1, 1'b0, '0, '0, '0);

    // Reset in the middle of VOTE (counter at 3)
    bus.A_DATA = 8'h5A;
    bus.B_DATA = 8'hFF;
    bus.C_DATA = 8'h00;
    bus.REQ_VALID = 1'b1;
    t = 0;
    while (bus.REQ_READY !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk("midrst_accept_timeout", 32'(t < 40), 32'd1);
    step();
    bus.REQ_VALID = 1'b0;
    repeat (3) step();
    rn = 1'b0;
    step();
    chk("midrst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("midrst_res_valid", 32'(bus.RES_VALID), 32'd0);
    chk("midrst_err", 32'(bus.ERR), 32'd0);
    chk("midrst_drivers", {bus.VA, bus.VB, bus.VC}, 3'b000);
    rn = 1'b1;
    step();
    chk("midrst_ready_back", 32'(bus.REQ_READY), 32'd1);
    bus.RES_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_stale", 32'(bus.RES_VALID), 32'd0);
    end
    bus.RES_READY = 1'b0;

    // Back-to-back accepts with REQ_VALID and RES_READY held high
    d1a = 8'hC3; d1b = 8'hC1; d1c = 8'h83;
    d2a = 8'h0F; d2b = 8'hF0; d2c = 8'h3C;
    bus.RES_READY = 1'b1;
    bus.A_DATA = d1a; bus.B_DATA = d1b; bus.C_DATA = d1c;
    bus.REQ_VALID = 1'b1;
    t = 0;
    while (bus.REQ_READY !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    chk("b2b_accept_timeout", 32'(t < 40), 32'd1);
    step();
    c1 = cyc;
    bus.A_DATA = d2a; bus.B_DATA = d2b; bus.C_DATA = d2c;
    got1 = 1'b0;
    c2 = -1;
    prev_ready = bus.REQ_READY;
    for (int i = 0; i < 30; i++) begin
      step();
      if (prev_ready) begin
        c2 = cyc;
        break;
      end
      if (bus.RES_VALID === 1'b1 && !got1) begin
        got1 = 1'b1;
        v = ref_vote(d1a, d1b, d1c);
        chk("b2b_data1", 32'(bus.RES_DATA), 32'(v));
        chk("b2b_err1", 32'(bus.ERR), 32'(ref_err(d1a, d1b, d1c, v)));
      end
      prev_ready = bus.REQ_READY;
    end
    bus.REQ_VALID = 1'b0;
    chk("b2b_got1", 32'(got1), 32'd1);
    chk("b2b_spacing", c2 - c1, W + 2);
    t = 0;
    while (bus.RES_VALID !== 1'b1 && t < 30) begin
      step();
      t++;
    end
    chk("b2b_res2_timeout", 32'(t < 30), 32'd1);
    chk("b2b_latency2", cyc - c2, W);
    v = ref_vote(d2a, d2b, d2c);
    chk("b2b_data2", 32'(bus.RES_DATA), 32'(v));
    chk("b2b_err2", 32'(bus.ERR), 32'(ref_err(d2a, d2b, d2c, v)));
    step();
    bus.RES_READY = 1'b0;

    // Cell stuck at 0: every vote reads as 1, checker (if built) flags it
    force_z = 1'b1;
    run_txn(8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, '0, '0, '0);
    force_z = 1'b0;
    run_txn(8'h69, 8'h69, 8'h68, 0, 1'b0, 1'b0, '0, '0, '0);
    rn = 1'b0;
    step();
    fault_exp = 1'b0;
    chk("fault_cleared", 32'(bus.CELL_FAULT), 32'd0);
    rn = 1'b1;
    step();

    // Randomized triples: mostly a reference word with sparse bit flips per copy
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      if (i % 4 == 3) begin
        b = W'($urandom);
        c = W'($urandom);
      end else begin
        b = a ^ W'(($urandom_range(0, 3) == 0) ? (1 << $urandom_range(0, W - 1)) : 0);
        c = a ^ W'(($urandom_range(0, 2) == 0) ? (1 << $urandom_range(0, W - 1)) : 0);
      end
      run_txn(a, b, c, $urandom_range(0, 3), 1'b0, 1'b0, '0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
